// File: rtl/obi_resp_pkg.sv
// Shared types and helpers for the OBI memory responder.
package obi_resp_pkg;

    // One queued response; writes carry zero data.
    typedef struct packed {
        logic [31:0] rdata;
    } obi_resp_t;

    // Replace the byte lanes of old_word selected by be with those of new_word.
    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/obi_mem_responder_if.sv
// OBI-style request/response bus between an initiator and the memory responder.
interface obi_mem_responder_if ();

    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;

    // Initiator side: drives the request, observes grant and response.
    modport master (
        output req_i,
        output addr_i,
        output we_i,
        output be_i,
        output wdata_i,
        input  gnt_o,
        input  rvalid_o,
        input  rdata_o
    );

    // Responder side: observes the request, drives grant and response.
    modport slave (
        input  req_i,
        input  addr_i,
        input  we_i,
        input  be_i,
        input  wdata_i,
        output gnt_o,
        output rvalid_o,
        output rdata_o
    );

endinterface

// File: rtl/obi_resp_fifo.sv
// In-order response queue; one entry per granted-but-unanswered transaction.
module obi_resp_fifo
    import obi_resp_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push_i,
    input  obi_resp_t                    push_data_i,
    input  logic                         pop_i,
    output obi_resp_t                    head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    obi_resp_t       store_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_ok, pop_ok;

    assign full_o  = (count_q == FullCnt);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = store_q[rd_ptr_q];
    assign count_o = count_q;

    // Next-state for pointers (wrapping at Depth, which need not be a power of two) and count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written at the tail on push.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(Depth); i++) begin
                store_q[i] <= '0;
            end
        end else if (push_ok) begin
            store_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pushes and pops are gated upstream; hitting either means a wiring bug.
    push_not_full: assert property (@(posedge clock) disable iff (reset) push_i |-> !full_o);
    pop_not_empty: assert property (@(posedge clock) disable iff (reset) pop_i |-> !empty_o);

endmodule

// File: rtl/obi_mem_responder.sv
// Memory-side OBI responder: grants requests, executes them on a word memory,
// answers in order through a response FIFO and flags initiator protocol violations.
module obi_mem_responder
    import obi_resp_pkg::*;
#(
    parameter int unsigned MEM_WORDS       = 16,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                 clock,
    input  logic                                 reset,
    obi_mem_responder_if.slave                   bus,
    input  logic                                 gnt_stall_i,
    input  logic                                 rvalid_stall_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 proto_err_o
);

    localparam int unsigned IdxW = $clog2(MEM_WORDS);

    logic [31:0]     mem_q [MEM_WORDS];
    logic [IdxW-1:0] word_idx;
    logic [31:0]     cur_word;

    logic      gnt;
    logic      rvalid;
    logic      fifo_full;
    logic      fifo_empty;
    obi_resp_t push_resp;
    obi_resp_t head_resp;

    logic        pend_q, pend_d;
    logic [31:0] hold_addr_q;
    logic        hold_we_q;
    logic [3:0]  hold_be_q;
    logic [31:0] hold_wdata_q;
    logic        held_changed;
    logic        proto_err_q, proto_err_d;

    // Upper and lower address bits are dropped, so addresses wrap modulo MEM_WORDS.
    assign word_idx = bus.addr_i[2 +: IdxW];
    assign cur_word = mem_q[word_idx];

    // fifo_full comes from the registered count, so a pop this cycle frees no slot yet.
    assign gnt       = bus.req_i && !gnt_stall_i && !fifo_full;
    assign bus.gnt_o = gnt;

    // Reads capture the word as it stands before this cycle's write.
    assign push_resp.rdata = bus.we_i ? 32'h0 : cur_word;

    assign rvalid       = !fifo_empty && !rvalid_stall_i;
    assign bus.rvalid_o = rvalid;
    assign bus.rdata_o  = rvalid ? head_resp.rdata : 32'h0;

    assign proto_err_o = proto_err_q;

    obi_resp_fifo #(
        .Depth (MAX_OUTSTANDING)
    ) u_resp_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (gnt),
        .push_data_i (push_resp),
        .pop_i       (rvalid),
        .head_o      (head_resp),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (outstanding_o)
    );

    // Word memory: byte-merged write on a granted write request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (gnt && bus.we_i) begin
            mem_q[word_idx] <= be_merge(cur_word, bus.wdata_i, bus.be_i);
        end
    end

    // Checker next-state: an ungranted request must be repeated unchanged next cycle.
    always_comb begin
        held_changed = (bus.addr_i != hold_addr_q) || (bus.we_i != hold_we_q) ||
                       (bus.be_i != hold_be_q) || (bus.wdata_i != hold_wdata_q);
        pend_d       = bus.req_i && !gnt;
        proto_err_d  = proto_err_q;
        if (pend_q && (!bus.req_i || held_changed)) begin
            proto_err_d = 1'b1;
        end
    end

    // Checker state: pending flag, captured request fields and the sticky error.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_q       <= 1'b0;
            hold_addr_q  <= '0;
            hold_we_q    <= 1'b0;
            hold_be_q    <= '0;
            hold_wdata_q <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            proto_err_q <= proto_err_d;
            if (pend_d) begin
                hold_addr_q  <= bus.addr_i;
                hold_we_q    <= bus.we_i;
                hold_be_q    <= bus.be_i;
                hold_wdata_q <= bus.wdata_i;
            end
        end
    end

endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed bench for obi_mem_responder; inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge.
module tb_obi_mem_responder;

    localparam int unsigned MEM_WORDS       = 16;
    localparam int unsigned MAX_OUTSTANDING = 2;
    localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1);

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             gnt_stall = 1'b0;
    logic             rvalid_stall = 1'b0;
    logic [CNT_W-1:0] outstanding;
    logic             proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    obi_mem_responder_if bus_if ();

    obi_mem_responder #(
        .MEM_WORDS       (MEM_WORDS),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus_if),
        .gnt_stall_i    (gnt_stall),
        .rvalid_stall_i (rvalid_stall),
        .outstanding_o  (outstanding),
        .proto_err_o    (proto_err)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        bus_if.req_i   = req;
        bus_if.we_i    = we;
        bus_if.addr_i  = addr;
        bus_if.wdata_i = wdata;
        bus_if.be_i    = be;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Sample the current cycle on the falling edge, then advance to the next cycle.
    task automatic expect_cycle(input string tag, input logic gnt, input logic rv,
                                input logic [31:0] rd, input logic [CNT_W-1:0] outs,
                                input logic perr);
        @(negedge clock);
        check_eq({tag, ".gnt"}, 32'(bus_if.gnt_o), 32'(gnt));
        check_eq({tag, ".rvalid"}, 32'(bus_if.rvalid_o), 32'(rv));
        check_eq({tag, ".rdata"}, bus_if.rdata_o, rd);
        check_eq({tag, ".outstanding"}, 32'(outstanding), 32'(outs));
        check_eq({tag, ".proto_err"}, 32'(proto_err), 32'(perr));
        next_cycle();
    endtask

    initial begin
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Reset state
        #3;
        check_eq("rst.gnt", 32'(bus_if.gnt_o), 32'h0);
        check_eq("rst.rvalid", 32'(bus_if.rvalid_o), 32'h0);
        check_eq("rst.rdata", bus_if.rdata_o, 32'h0);
        check_eq("rst.outstanding", 32'(outstanding), 32'h0);
        check_eq("rst.proto_err", 32'(proto_err), 32'h0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // Write then read, back-to-back
        drive(1'b1, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF);
        expect_cycle("wr_rd.c0", 1'b1, 1'b0, 32'h0, 2'd0, 1'b0);
        drive(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        expect_cycle("wr_rd.c1", 1'b1, 1'b1, 32'h0, 2'd1, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        expect_cycle("wr_rd.c2", 1'b0, 1'b1, 32'hDEADBEEF, 2'd1, 1'b0);
        expect_cycle("wr_rd.c3", 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);

        // Byte enables: lanes 0 and 2 replaced
        drive(1'b1, 1'b1, 32'h4, 32'h11223344, 4'hF);
        expect_cycle("be.c0", 1'b1, 1'b0, 32'h0, 2'd0, 1'b0);
        drive(1'b1, 1'b1, 32'h4, 32'hAABBCCDD, 4'h5);
        expect_cycle("be.c1", 1'b1, 1'b1, 32'h0, 2'd1, 1'b0);
        drive(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        expect_cycle("be.c2", 1'b1, 1'b1, 32'h0, 2'd1, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        expect_cycle("be.c3", 1'b0, 1'b1, 32'h11BB33DD, 2'd1, 1'b0);
        expect_cycle("be.c4", 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);

        // Backpressure: two grants fill the queue, third waits for a pop
        rvalid_stall = 1'b1;
        drive(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        expect_cycle("bp.c0", 1'b1, 1'b0, 32'h0, 2'd0, 1'b0);
        drive(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        expect_cycle("bp.c1", 1'b1, 1'b0, 32'h0, 2'd1, 1'b0);
        expect_cycle("bp.c2", 1'b0, 1'b0, 32'h0, 2'd2, 1'b0);
        expect_cycle("bp.c3", 1'b0, 1'b0, 32'h0, 2'd2, 1'b0);
        rvalid_stall = 1'b0;
        expect_cycle("bp.c4", 1'b0, 1'b1, 32'hDEADBEEF, 2'd2, 1'b0);
        expect_cycle("bp.c5", 1'b1, 1'b1, 32'h11BB33DD, 2'd1, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        expect_cycle("bp.c6", 1'b0, 1'b1, 32'h11BB33DD, 2'd1, 1'b0);
        expect_cycle("bp.c7", 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);

        // Address wrap: 0x40 aliases word 0
        drive(1'b1, 1'b1, 32'h40, 32'h55, 4'hF);
        expect_cycle("wrap.c0", 1'b1, 1'b0, 32'h0, 2'd0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        expect_cycle("wrap.c1", 1'b1, 1'b1, 32'h0, 2'd1, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        expect_cycle("wrap.c2", 1'b0, 1'b1, 32'h55, 2'd1, 1'b0);
        expect_cycle("wrap.c3", 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);

        // Protocol error: address changes while the request is stalled
        gnt_stall = 1'b1;
        drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        expect_cycle("perr.c0", 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        drive(1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
        expect_cycle("perr.c1", 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        gnt_stall = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        expect_cycle("perr.c2", 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
        expect_cycle("perr.c3", 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
        expect_cycle("perr.c4", 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);

        // Reset with two responses outstanding
        rvalid_stall = 1'b1;
        drive(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        expect_cycle("rst2.c0", 1'b1, 1'b0, 32'h0, 2'd0, 1'b1);
        expect_cycle("rst2.c1", 1'b1, 1'b0, 32'h0, 2'd1, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        expect_cycle("rst2.c2", 1'b0, 1'b0, 32'h0, 2'd2, 1'b1);
        rvalid_stall = 1'b0;
        #1;
        check_eq("rst2.pre_rvalid", 32'(bus_if.rvalid_o), 32'h1);
        check_eq("rst2.pre_rdata", bus_if.rdata_o, 32'hDEADBEEF);
        #1;
        reset = 1'b1;
        #1;
        check_eq("rst2.async_rvalid", 32'(bus_if.rvalid_o), 32'h0);
        check_eq("rst2.async_outstanding", 32'(outstanding), 32'h0);
        check_eq("rst2.async_proto_err", 32'(proto_err), 32'h0);
        next_cycle();
        reset = 1'b0;
        expect_cycle("rst2.idle0", 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        expect_cycle("rst2.idle1", 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
        expect_cycle("rst2.idle2", 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);

        // Memory was cleared by reset
        drive(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        expect_cycle("memclr.c0", 1'b1, 1'b0, 32'h0, 2'd0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        expect_cycle("memclr.c1", 1'b0, 1'b1, 32'h0, 2'd1, 1'b0);
        expect_cycle("memclr.c2", 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
